// File: rtl/core_fetch_pc_gen_if.sv
// ---------------------------------------------------------------------------
// core_fetch_pc_gen_if
// Bundles the fetch-side outputs and backend-side inputs of the fetch PC
// generator.
//   master : the PC generator. It drives the fetch group and the prediction,
//            and it receives redirect, stall and training.
//   slave  : the front end / backend. It consumes the fetch group and drives
//            redirect, stall and training.
// Signals:
//   redirect_i, redirect_target_i  backend flush and its target PC
//   stall_i                        hold the current fetch PC
//   pc_o, npc_o                    current and next fetch PC
//   valid_o, pred_taken_o          per-slot valid mask and taken prediction
//   pred_target_o                  target of the first predicted-taken slot
//   upd_*                          BTB training from branch resolution
// ---------------------------------------------------------------------------
interface core_fetch_pc_gen_if;
    logic        redirect_i;
    logic [31:0] redirect_target_i;
    logic        stall_i;
    logic [31:0] pc_o;
    logic [31:0] npc_o;
    logic [1:0]  valid_o;
    logic [1:0]  pred_taken_o;
    logic [31:0] pred_target_o;
    logic        upd_valid_i;
    logic [31:0] upd_pc_i;
    logic        upd_taken_i;
    logic [31:0] upd_target_i;

    modport master (
        input  redirect_i, redirect_target_i, stall_i,
        input  upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
        output pc_o, npc_o, valid_o, pred_taken_o, pred_target_o
    );

    modport slave (
        output redirect_i, redirect_target_i, stall_i,
        output upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
        input  pc_o, npc_o, valid_o, pred_taken_o, pred_target_o
    );
endinterface

// File: rtl/core_fetch_pc_gen.sv
// ---------------------------------------------------------------------------
// core_fetch_pc_gen
// Fetch-group PC generator with a direct-mapped, two-slot BTB.
// Each cycle it presents an 8-byte fetch group at pc_o and its slot-valid
// mask. It also presents the per-slot taken prediction and the predicted
// target. npc_o is the PC that pc_o takes at the next edge.
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   fe   core_fetch_pc_gen_if.master (redirect/stall/training in,
//        fetch group and prediction out)
// ---------------------------------------------------------------------------
module core_fetch_pc_gen #(
    parameter logic [31:0] RESET_PC    = 32'h1c000000,
    parameter int          BTB_ENTRIES = 64
) (
    input  logic                clk,
    input  logic                rst,
    core_fetch_pc_gen_if.master fe
);
    localparam int IDX = $clog2(BTB_ENTRIES);
    localparam int TAG = 32 - IDX - 3;

    logic [31:0]    pc_reg;
    logic [31:0]    pc_next;
    logic [31:0]    seq_pc;

    logic [IDX-1:0] rd_set;
    logic [TAG-1:0] rd_tag;
    logic [IDX-1:0] wr_set;
    logic [TAG-1:0] wr_tag;

    logic [1:0]     slot_hit;
    logic [29:0]    slot_target [2];
    logic           hit0;
    logic           hit1;

    // The low bits are don't-care because all addresses are word aligned.
    logic           unused_bits;
    assign unused_bits = ^{fe.upd_pc_i[1:0], fe.upd_target_i[1:0]};

    assign rd_set = pc_reg[IDX+2:3];
    assign rd_tag = pc_reg[31:IDX+3];
    assign wr_set = fe.upd_pc_i[IDX+2:3];
    assign wr_tag = fe.upd_pc_i[31:IDX+3];

    // One BTB bank per slot. Each bank has its own flop array and a
    // combinational read. Only the valid bits are reset, so the payload
    // arrays stay reset-free.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_slot
            localparam logic SLOT = 1'(gi);

            logic [BTB_ENTRIES-1:0] valid_reg;
            logic [TAG-1:0]         tag_mem    [BTB_ENTRIES];
            logic [29:0]            target_mem [BTB_ENTRIES];
            logic [1:0]             ctr_mem    [BTB_ENTRIES];

            logic       upd_sel;
            logic       upd_hit;
            logic       write_en;
            logic [1:0] ctr_cur;
            logic [1:0] ctr_next;

            assign upd_sel  = fe.upd_valid_i & (fe.upd_pc_i[2] == SLOT);
            assign upd_hit  = valid_reg[wr_set] & (tag_mem[wr_set] == wr_tag);
            assign ctr_cur  = ctr_mem[wr_set];
            // A not-taken branch that misses is not worth allocating.
            assign write_en = upd_sel & (upd_hit | fe.upd_taken_i);

            // 2-bit saturating counter
            always_comb begin
                ctr_next = ctr_cur;
                if (fe.upd_taken_i) begin
                    if (ctr_cur != 2'b11) ctr_next = ctr_cur + 2'd1;
                end else begin
                    if (ctr_cur != 2'b00) ctr_next = ctr_cur - 2'd1;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg <= '0;
                end else if (write_en) begin
                    valid_reg[wr_set] <= 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (write_en) begin
                    tag_mem[wr_set] <= wr_tag;
                    ctr_mem[wr_set] <= upd_hit ? ctr_next : 2'b10;
                    if (fe.upd_taken_i) begin
                        target_mem[wr_set] <= fe.upd_target_i[31:2];
                    end
                end
            end

            // The read sees the pre-edge contents, so a same-cycle update is
            // visible only from the next cycle.
            assign slot_hit[gi]    = valid_reg[rd_set] & (tag_mem[rd_set] == rd_tag)
                                     & ctr_mem[rd_set][1];
            assign slot_target[gi] = target_mem[rd_set];
        end
    endgenerate

    // Slot 0 is not part of the group when the PC points at the upper word.
    assign hit0 = slot_hit[0] & ~pc_reg[2];
    assign hit1 = slot_hit[1];

    assign seq_pc = {pc_reg[31:3] + 29'd1, 3'b000};

    always_comb begin
        pc_next = seq_pc;
        if (fe.redirect_i) begin
            pc_next = fe.redirect_target_i;
        end else if (fe.stall_i) begin
            pc_next = pc_reg;
        end else if (hit0) begin
            pc_next = {slot_target[0], 2'b00};
        end else if (hit1) begin
            pc_next = {slot_target[1], 2'b00};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg <= RESET_PC;
        end else begin
            pc_reg <= pc_next;
        end
    end

    assign fe.pc_o          = pc_reg;
    assign fe.npc_o         = pc_next;
    // A taken slot 0 ends the group, so slot 1 is dropped.
    assign fe.valid_o       = {~hit0, ~pc_reg[2]};
    assign fe.pred_taken_o  = {hit1 & ~hit0, hit0};
    assign fe.pred_target_o = hit0 ? {slot_target[0], 2'b00} :
                              hit1 ? {slot_target[1], 2'b00} : 32'h0;
endmodule

// File: tb/tb_core_fetch_pc_gen.sv
// ---------------------------------------------------------------------------
// tb_core_fetch_pc_gen
// Scoreboard bench for the fetch PC generator. Each scenario queues
// per-cycle stimulus together with the outputs it expects for that cycle.
// It then replays the queue and compares pc_o, npc_o, valid_o,
// pred_taken_o and pred_target_o as a single packed record.
// ---------------------------------------------------------------------------
module tb_core_fetch_pc_gen;
    localparam logic [31:0] B = 32'h1c000000;

    typedef struct packed {
        logic        redirect;
        logic [31:0] rtgt;
        logic        stall;
        logic        upd;
        logic [31:0] upc;
        logic        utaken;
        logic [31:0] utgt;
    } stim_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] npc;
        logic [1:0]  valid;
        logic [1:0]  pt;
        logic [31:0] tgt;
    } exp_t;

    logic clk;
    logic rst;
    core_fetch_pc_gen_if bus();

    core_fetch_pc_gen #(.RESET_PC(B), .BTB_ENTRIES(64)) dut (
        .clk(clk),
        .rst(rst),
        .fe (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    stim_t stim_q[$];
    exp_t  exp_q[$];
    int    checks = 0;
    int    passed = 0;

    function automatic stim_t st(logic r, logic [31:0] rt, logic s, logic u,
                                 logic [31:0] up, logic ut, logic [31:0] utg);
        stim_t x;
        x.redirect = r; x.rtgt = rt; x.stall = s;
        x.upd = u; x.upc = up; x.utaken = ut; x.utgt = utg;
        return x;
    endfunction

    function automatic exp_t ex(logic [31:0] pc, logic [31:0] npc, logic [1:0] v,
                                logic [1:0] pt, logic [31:0] tgt);
        exp_t x;
        x.pc = pc; x.npc = npc; x.valid = v; x.pt = pt; x.tgt = tgt;
        return x;
    endfunction

    function automatic stim_t idle();
        return st(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endfunction

    function automatic stim_t redir(logic [31:0] t);
        return st(1'b1, t, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endfunction

    function automatic stim_t train(logic [31:0] p, logic tk, logic [31:0] t);
        return st(1'b0, 32'h0, 1'b0, 1'b1, p, tk, t);
    endfunction

    task automatic push(stim_t s, exp_t e);
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    task automatic apply(stim_t s);
        bus.redirect_i        = s.redirect;
        bus.redirect_target_i = s.rtgt;
        bus.stall_i           = s.stall;
        bus.upd_valid_i       = s.upd;
        bus.upd_pc_i          = s.upc;
        bus.upd_taken_i       = s.utaken;
        bus.upd_target_i      = s.utgt;
    endtask

    // Holds a redirect while reset is asserted, so reset must win it.
    task automatic do_reset();
        apply(redir(32'h00000040));
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        apply(idle());
    endtask

    task automatic test_reset();
        exp_t e; exp_t o; stim_t s; int n = 0;
        do_reset();
        push(idle(), ex(B,         B + 32'h08, 2'b11, 2'b00, 32'h0));
        push(idle(), ex(B + 32'h08, B + 32'h10, 2'b11, 2'b00, 32'h0));
        push(idle(), ex(B + 32'h10, B + 32'h18, 2'b11, 2'b00, 32'h0));
        push(idle(), ex(B + 32'h18, B + 32'h20, 2'b11, 2'b00, 32'h0));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); apply(s); #1;
            e = exp_q.pop_front();
            o = {bus.pc_o, bus.npc_o, bus.valid_o, bus.pred_taken_o, bus.pred_target_o};
            checks++;
            if (o !== e) $display("FAIL reset[%0d]: got %h required %h", n, o, e);
            else begin passed++; $display("reset[%0d] pc=%h npc=%h ok", n, o.pc, o.npc); end
            n++; @(posedge clk); #1;
        end
    endtask

    task automatic test_redirect_stall();
        exp_t e; exp_t o; stim_t s; int n = 0;
        push(st(1'b1, B + 32'h104, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0),
             ex(B + 32'h20, B + 32'h104, 2'b11, 2'b00, 32'h0));
        push(idle(), ex(B + 32'h104, B + 32'h108, 2'b10, 2'b00, 32'h0));
        push(idle(), ex(B + 32'h108, B + 32'h110, 2'b11, 2'b00, 32'h0));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); apply(s); #1;
            e = exp_q.pop_front();
            o = {bus.pc_o, bus.npc_o, bus.valid_o, bus.pred_taken_o, bus.pred_target_o};
            checks++;
            if (o !== e) $display("FAIL redirect_stall[%0d]: got %h required %h", n, o, e);
            else begin passed++; $display("redirect_stall[%0d] pc=%h npc=%h ok", n, o.pc, o.npc); end
            n++; @(posedge clk); #1;
        end
    endtask

    task automatic test_train_predict();
        exp_t e; exp_t o; stim_t s; int n = 0;
        do_reset();
        push(train(B + 32'h20, 1'b1, B + 32'h400), ex(B, B + 32'h08, 2'b11, 2'b00, 32'h0));
        push(redir(B + 32'h20), ex(B + 32'h08, B + 32'h20, 2'b11, 2'b00, 32'h0));
        push(idle(), ex(B + 32'h20, B + 32'h400, 2'b01, 2'b01, B + 32'h400));
        push(idle(), ex(B + 32'h400, B + 32'h408, 2'b11, 2'b00, 32'h0));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); apply(s); #1;
            e = exp_q.pop_front();
            o = {bus.pc_o, bus.npc_o, bus.valid_o, bus.pred_taken_o, bus.pred_target_o};
            checks++;
            if (o !== e) $display("FAIL train_predict[%0d]: got %h required %h", n, o, e);
            else begin passed++; $display("train_predict[%0d] pc=%h npc=%h ok", n, o.pc, o.npc); end
            n++; @(posedge clk); #1;
        end
    endtask

    // Continues from the entry at B+0x20 with counter 2'b10.
    task automatic test_counter();
        exp_t e; exp_t o; stim_t s; int n = 0;
        push(train(B + 32'h20, 1'b0, 32'h0), ex(B + 32'h408, B + 32'h410, 2'b11, 2'b00, 32'h0)); // ->01
        push(st(1'b1, B + 32'h20, 1'b0, 1'b1, B + 32'h20, 1'b0, 32'h0),
             ex(B + 32'h410, B + 32'h20, 2'b11, 2'b00, 32'h0));                                   // ->00
        push(idle(), ex(B + 32'h20, B + 32'h28, 2'b11, 2'b00, 32'h0));
        push(train(B + 32'h20, 1'b0, 32'h0), ex(B + 32'h28, B + 32'h30, 2'b11, 2'b00, 32'h0));  // stays 00
        push(st(1'b1, B + 32'h20, 1'b0, 1'b1, B + 32'h20, 1'b1, B + 32'h400),
             ex(B + 32'h30, B + 32'h20, 2'b11, 2'b00, 32'h0));                                    // ->01
        push(idle(), ex(B + 32'h20, B + 32'h28, 2'b11, 2'b00, 32'h0));
        push(st(1'b1, B + 32'h20, 1'b0, 1'b1, B + 32'h20, 1'b1, B + 32'h400),
             ex(B + 32'h28, B + 32'h20, 2'b11, 2'b00, 32'h0));                                    // ->10
        push(train(B + 32'h20, 1'b1, B + 32'h400),
             ex(B + 32'h20, B + 32'h400, 2'b01, 2'b01, B + 32'h400));                             // ->11
        push(st(1'b1, B + 32'h20, 1'b0, 1'b1, B + 32'h20, 1'b1, B + 32'h400),
             ex(B + 32'h400, B + 32'h20, 2'b11, 2'b00, 32'h0));                                   // stays 11
        push(st(1'b1, B + 32'h20, 1'b0, 1'b1, B + 32'h20, 1'b0, 32'h0),
             ex(B + 32'h20, B + 32'h20, 2'b01, 2'b01, B + 32'h400));                              // ->10
        push(idle(), ex(B + 32'h20, B + 32'h400, 2'b01, 2'b01, B + 32'h400));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); apply(s); #1;
            e = exp_q.pop_front();
            o = {bus.pc_o, bus.npc_o, bus.valid_o, bus.pred_taken_o, bus.pred_target_o};
            checks++;
            if (o !== e) $display("FAIL counter[%0d]: got %h required %h", n, o, e);
            else begin passed++; $display("counter[%0d] pc=%h npc=%h ok", n, o.pc, o.npc); end
            n++; @(posedge clk); #1;
        end
    endtask

    // Training is accepted during the stall.
    task automatic test_stall();
        exp_t e; exp_t o; stim_t s; int n = 0;
        stim_t hold;
        do_reset();
        hold = st(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        push(hold, ex(B, B, 2'b11, 2'b00, 32'h0));
        push(st(1'b0, 32'h0, 1'b1, 1'b1, B + 32'h08, 1'b1, B + 32'h700), ex(B, B, 2'b11, 2'b00, 32'h0));
        push(hold, ex(B, B, 2'b11, 2'b00, 32'h0));
        push(hold, ex(B, B, 2'b11, 2'b00, 32'h0));
        push(hold, ex(B, B, 2'b11, 2'b00, 32'h0));
        push(idle(), ex(B, B + 32'h08, 2'b11, 2'b00, 32'h0));
        push(idle(), ex(B + 32'h08, B + 32'h700, 2'b01, 2'b01, B + 32'h700));
        push(idle(), ex(B + 32'h700, B + 32'h708, 2'b11, 2'b00, 32'h0));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); apply(s); #1;
            e = exp_q.pop_front();
            o = {bus.pc_o, bus.npc_o, bus.valid_o, bus.pred_taken_o, bus.pred_target_o};
            checks++;
            if (o !== e) $display("FAIL stall[%0d]: got %h required %h", n, o, e);
            else begin passed++; $display("stall[%0d] pc=%h npc=%h ok", n, o.pc, o.npc); end
            n++; @(posedge clk); #1;
        end
    endtask

    // B+0x20 and B+0x220 share a set, so the second allocation evicts the first.
    task automatic test_alias();
        exp_t e; exp_t o; stim_t s; int n = 0;
        do_reset();
        push(train(B + 32'h20, 1'b1, B + 32'h400), ex(B, B + 32'h08, 2'b11, 2'b00, 32'h0));
        push(train(B + 32'h220, 1'b1, B + 32'h800), ex(B + 32'h08, B + 32'h10, 2'b11, 2'b00, 32'h0));
        push(redir(B + 32'h20), ex(B + 32'h10, B + 32'h20, 2'b11, 2'b00, 32'h0));
        push(idle(), ex(B + 32'h20, B + 32'h28, 2'b11, 2'b00, 32'h0));
        push(redir(B + 32'h220), ex(B + 32'h28, B + 32'h220, 2'b11, 2'b00, 32'h0));
        push(idle(), ex(B + 32'h220, B + 32'h800, 2'b01, 2'b01, B + 32'h800));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); apply(s); #1;
            e = exp_q.pop_front();
            o = {bus.pc_o, bus.npc_o, bus.valid_o, bus.pred_taken_o, bus.pred_target_o};
            checks++;
            if (o !== e) $display("FAIL alias[%0d]: got %h required %h", n, o, e);
            else begin passed++; $display("alias[%0d] pc=%h npc=%h ok", n, o.pc, o.npc); end
            n++; @(posedge clk); #1;
        end
    endtask

    // Slot 1 prediction. A slot-0 entry is ignored when pc_o[2] is 1.
    task automatic test_slot1();
        exp_t e; exp_t o; stim_t s; int n = 0;
        do_reset();
        push(train(B + 32'h104, 1'b1, B + 32'h300), ex(B, B + 32'h08, 2'b11, 2'b00, 32'h0));
        push(train(B + 32'h200, 1'b1, B + 32'h500), ex(B + 32'h08, B + 32'h10, 2'b11, 2'b00, 32'h0));
        push(redir(B + 32'h100), ex(B + 32'h10, B + 32'h100, 2'b11, 2'b00, 32'h0));
        push(idle(), ex(B + 32'h100, B + 32'h300, 2'b11, 2'b10, B + 32'h300));
        push(redir(B + 32'h104), ex(B + 32'h300, B + 32'h104, 2'b11, 2'b00, 32'h0));
        push(idle(), ex(B + 32'h104, B + 32'h300, 2'b10, 2'b10, B + 32'h300));
        push(redir(B + 32'h204), ex(B + 32'h300, B + 32'h204, 2'b11, 2'b00, 32'h0));
        push(idle(), ex(B + 32'h204, B + 32'h208, 2'b10, 2'b00, 32'h0));
        push(redir(B + 32'h200), ex(B + 32'h208, B + 32'h200, 2'b11, 2'b00, 32'h0));
        push(idle(), ex(B + 32'h200, B + 32'h500, 2'b01, 2'b01, B + 32'h500));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); apply(s); #1;
            e = exp_q.pop_front();
            o = {bus.pc_o, bus.npc_o, bus.valid_o, bus.pred_taken_o, bus.pred_target_o};
            checks++;
            if (o !== e) $display("FAIL slot1[%0d]: got %h required %h", n, o, e);
            else begin passed++; $display("slot1[%0d] pc=%h npc=%h ok", n, o.pc, o.npc); end
            n++; @(posedge clk); #1;
        end
    endtask

    // Continues from pc B+0x500.
    task automatic test_wrap();
        exp_t e; exp_t o; stim_t s; int n = 0;
        push(redir(32'hfffffffc), ex(B + 32'h500, 32'hfffffffc, 2'b11, 2'b00, 32'h0));
        push(idle(), ex(32'hfffffffc, 32'h00000000, 2'b10, 2'b00, 32'h0));
        push(idle(), ex(32'h00000000, 32'h00000008, 2'b11, 2'b00, 32'h0));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); apply(s); #1;
            e = exp_q.pop_front();
            o = {bus.pc_o, bus.npc_o, bus.valid_o, bus.pred_taken_o, bus.pred_target_o};
            checks++;
            if (o !== e) $display("FAIL wrap[%0d]: got %h required %h", n, o, e);
            else begin passed++; $display("wrap[%0d] pc=%h npc=%h ok", n, o.pc, o.npc); end
            n++; @(posedge clk); #1;
        end
    endtask

    // Training the entry being read in the same cycle returns the old contents.
    task automatic test_read_during_write();
        exp_t e; exp_t o; stim_t s; int n = 0;
        do_reset();
        push(redir(B + 32'h20), ex(B, B + 32'h20, 2'b11, 2'b00, 32'h0));
        push(train(B + 32'h20, 1'b1, B + 32'h400), ex(B + 32'h20, B + 32'h28, 2'b11, 2'b00, 32'h0));
        push(redir(B + 32'h20), ex(B + 32'h28, B + 32'h20, 2'b11, 2'b00, 32'h0));
        push(idle(), ex(B + 32'h20, B + 32'h400, 2'b01, 2'b01, B + 32'h400));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); apply(s); #1;
            e = exp_q.pop_front();
            o = {bus.pc_o, bus.npc_o, bus.valid_o, bus.pred_taken_o, bus.pred_target_o};
            checks++;
            if (o !== e) $display("FAIL read_during_write[%0d]: got %h required %h", n, o, e);
            else begin passed++; $display("read_during_write[%0d] pc=%h npc=%h ok", n, o.pc, o.npc); end
            n++; @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        apply(idle());
        test_reset();
        test_redirect_stall();
        test_train_predict();
        test_counter();
        test_stall();
        test_alias();
        test_slot1();
        test_wrap();
        test_read_during_write();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
